// File: rtl/accum_cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state, opcode and ALU encodings for the accumulator CPU.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        F_ADDR,
        F_MEM,
        DECODE,
        O_ADDR,
        O_MEM,
        HALT
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/mem_ack_watchdog.sv
// mem_ack_watchdog: counts unacknowledged memory wait cycles and flags a timeout.
module mem_ack_watchdog #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    // Idle cycles hold the count at zero, so it is clear on every entry to a memory state.
    always_ff @(posedge clk)
        count <= (rst || !active || ack) ? '0 : count + W'(1);

    assign expire = active && !ack && count == W'(TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/accum_cpu_ctrl.sv
// accum_cpu_ctrl: fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Define MEM_TIMEOUT_EN to halt with a sticky fault when memory never acknowledges.
module accum_cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic       acc_zero,
    input  logic       mem_ack,
    output logic       pc_load,
    output logic       pc_inc,
    output logic       ir_load,
    output logic       mar_load,
    output logic       mar_sel,
    output logic       acc_load,
    output logic       acc_sel,
    output logic [1:0] alu_op,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       halted,
    output logic       fault
);
    state_t state, next;
    logic   ack;
    logic   expire;

    // A reset cycle must never let an acknowledge turn into a load strobe.
    assign ack = mem_ack && !rst;

`ifdef MEM_TIMEOUT_EN
    logic fault_q;

    mem_ack_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk    (clk),
        .rst    (rst),
        .active (state == F_MEM || state == O_MEM),
        .ack    (ack),
        .expire (expire)
    );

    always_ff @(posedge clk)
        fault_q <= rst ? 1'b0 : fault_q | expire;

    assign fault = fault_q;
`else
    logic unused_cfg;

    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign expire     = 1'b0;
    assign fault      = 1'b0;
`endif

    always_ff @(posedge clk)
        state <= rst ? IDLE : next;

    always_comb begin
        next     = state;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        ir_load  = 1'b0;
        mar_load = 1'b0;
        mar_sel  = 1'b0;
        acc_load = 1'b0;
        acc_sel  = 1'b0;
        alu_op   = ALU_PASS;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        halted   = 1'b0;
        case (state)
            IDLE:    next = start ? F_ADDR : IDLE;
            F_ADDR: begin
                mar_load = 1'b1;
                next     = F_MEM;
            end
            F_MEM: begin
                mem_rd  = 1'b1;
                ir_load = ack;
                pc_inc  = ack;
                next    = ack ? DECODE : F_MEM;
            end
            DECODE: begin
                pc_load = opcode == OP_JMP || (opcode == OP_JZ && acc_zero);
                next    = opcode == OP_HLT ? HALT :
                          (opcode == OP_NOP || opcode == OP_JMP || opcode == OP_JZ) ? F_ADDR : O_ADDR;
            end
            O_ADDR: begin
                mar_load = 1'b1;
                mar_sel  = 1'b1;
                next     = O_MEM;
            end
            O_MEM: begin
                mem_wr   = opcode == OP_STA;
                mem_rd   = opcode != OP_STA;
                acc_load = ack && opcode != OP_STA;
                acc_sel  = ack && (opcode == OP_ADD || opcode == OP_SUB);
                alu_op   = !ack ? ALU_PASS : opcode == OP_ADD ? ALU_ADD :
                           opcode == OP_SUB ? ALU_SUB : ALU_PASS;
                next     = ack ? F_ADDR : O_MEM;
            end
            HALT:    halted = 1'b1;
            default: next = IDLE;
        endcase
        if (expire)
            next = HALT;
    end

endmodule
